// File: rtl/wb_pipe_stage_pkg.sv
// ============================================================================
// Module : wb_pipe_stage_pkg
// Brief  : Shared defines and helpers for the MEM->WB write-back pipeline stage.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

`ifndef WB_PIPE_STAGE_DEFINES
`define WB_PIPE_STAGE_DEFINES
`define True                     1'b1
`define False                    1'b0
`define ZeroWord                 32'h0000_0000
`define NOPRegAddr               5'b00000
`define WB_LANES_DEF             1
`define WB_REC_W(addr_w, data_w) ((addr_w) + 1 + (data_w))
`endif

package wb_pipe_stage_pkg;

    localparam int C_CNT_W = 32;

    // Number of set bits in a request vector of up to 32 lanes.
    function automatic logic [5:0] popcount32(input logic [31:0] v);
        logic [5:0] cnt;
        cnt = 6'd0;
        for (int i = 0; i < 32; i++) begin
            cnt = cnt + 6'(v[i]);
        end
        return cnt;
    endfunction

endpackage

`default_nettype wire

// File: rtl/wb_skid_slot.sv
// ============================================================================
// Module : wb_skid_slot
// Brief  : One valid+payload register with load and clear; clear wins.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module wb_skid_slot #(
    parameter int WIDTH = 38
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             clear,
    input  logic [WIDTH-1:0] d,
    output logic             valid,
    output logic [WIDTH-1:0] q
);

    logic             r_valid;
    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_q     <= '0;
        end else if (clear) begin
            r_valid <= 1'b0;
        end else if (load) begin
            r_valid <= 1'b1;
            r_q     <= d;
        end
    end

    assign valid = r_valid;
    assign q     = r_q;

endmodule

`default_nettype wire

// File: rtl/wb_pipe_stage.sv
// ============================================================================
// Module : wb_pipe_stage
// Brief  : Multi-lane MEM->WB register with valid/ready, 2-entry skid buffer,
//          flush and x0-write filtering. Optional perf counters: WB_PIPE_PERF_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module wb_pipe_stage
    import wb_pipe_stage_pkg::*;
#(
    parameter int LANES         = `WB_LANES_DEF,
    parameter int ADDR_W        = 5,
    parameter int DATA_W        = 32,
    parameter int ZERO_REG_DROP = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rdy,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*ADDR_W-1:0] in_w_addr,
    input  logic [LANES-1:0]        in_w_req,
    input  logic [LANES*DATA_W-1:0] in_w_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*ADDR_W-1:0] out_w_addr,
    output logic [LANES-1:0]        out_w_req,
    output logic [LANES*DATA_W-1:0] out_w_data
`ifdef WB_PIPE_PERF_EN
    ,
    output logic [C_CNT_W-1:0]      perf_stall_cnt,
    output logic [C_CNT_W-1:0]      perf_wr_cnt
`endif
);

    localparam int LANE_W = `WB_REC_W(ADDR_W, DATA_W);
    localparam int REC_W  = LANES * LANE_W;

    logic [REC_W-1:0] w_in_rec;
    logic [REC_W-1:0] w_main_d;
    logic [REC_W-1:0] w_main_q;
    logic [REC_W-1:0] w_skid_q;
    logic             w_main_valid;
    logic             w_skid_valid;
    logic             w_accept;
    logic             w_retire;
    logic             w_main_load;
    logic             w_main_clear;
    logic             w_skid_load;
    logic             w_skid_clear;

    // Per-lane record {data, req, addr}; req is filtered for x0 on capture.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic w_req_f;
        assign w_req_f = in_w_req[i] &
                         ~((ZERO_REG_DROP != 0) && (in_w_addr[i*ADDR_W +: ADDR_W] == '0));
        assign w_in_rec[i*LANE_W +: LANE_W] = {in_w_data[i*DATA_W +: DATA_W], w_req_f,
                                               in_w_addr[i*ADDR_W +: ADDR_W]};
        assign out_w_addr[i*ADDR_W +: ADDR_W] = w_main_q[i*LANE_W +: ADDR_W];
        assign out_w_req[i]                   = w_main_q[i*LANE_W + ADDR_W] & w_main_valid;
        assign out_w_data[i*DATA_W +: DATA_W] = w_main_q[i*LANE_W + ADDR_W + 1 +: DATA_W];
    end

    // Only skid_valid is stateful here; rdy/flush just gate it, so a full
    // skid blocks input starting the cycle after it fills.
    assign in_ready  = rdy & ~w_skid_valid & ~flush;
    assign out_valid = w_main_valid;

    assign w_accept = in_valid & in_ready;
    assign w_retire = w_main_valid & out_ready & rdy;

    assign w_main_load  = rdy & ~flush & (~w_main_valid | w_retire) & (w_skid_valid | w_accept);
    assign w_main_clear = rdy & (flush | (w_retire & ~w_main_load));
    assign w_main_d     = w_skid_valid ? w_skid_q : w_in_rec;

    assign w_skid_load  = rdy & ~flush & w_accept & w_main_valid & ~w_retire;
    assign w_skid_clear = rdy & (flush | (w_skid_valid & w_main_load));

    wb_skid_slot #(
        .WIDTH (REC_W)
    ) u_main (
        .clk   (clk),
        .rst   (rst),
        .load  (w_main_load),
        .clear (w_main_clear),
        .d     (w_main_d),
        .valid (w_main_valid),
        .q     (w_main_q)
    );

    wb_skid_slot #(
        .WIDTH (REC_W)
    ) u_skid (
        .clk   (clk),
        .rst   (rst),
        .load  (w_skid_load),
        .clear (w_skid_clear),
        .d     (w_in_rec),
        .valid (w_skid_valid),
        .q     (w_skid_q)
    );

`ifdef WB_PIPE_PERF_EN
    logic [C_CNT_W-1:0] r_stall_cnt;
    logic [C_CNT_W-1:0] r_wr_cnt;
    logic [5:0]         w_wr_pop;

    assign w_wr_pop = popcount32(32'(out_w_req));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_wr_cnt    <= '0;
        end else if (rdy) begin
            if (w_main_valid & ~out_ready) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (w_retire) begin
                r_wr_cnt <= r_wr_cnt + 32'(w_wr_pop);
            end
        end
    end

    assign perf_stall_cnt = r_stall_cnt;
    assign perf_wr_cnt    = r_wr_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_wb_pipe_stage.sv
// ============================================================================
// Module : tb_wb_pipe_stage
// Brief  : Scoreboard bench for wb_pipe_stage (LANES=2); honours WB_PIPE_PERF_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_wb_pipe_stage;

    localparam int LANES  = 2;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic [LANES*ADDR_W-1:0] addr;
        logic [LANES-1:0]        req;
        logic [LANES*DATA_W-1:0] data;
    } beat_t;

    logic                    clk = 1'b0;
    logic                    rst, rdy, flush, in_valid, in_ready, out_valid, out_ready;
    logic [LANES*ADDR_W-1:0] in_w_addr, out_w_addr;
    logic [LANES-1:0]        in_w_req, out_w_req;
    logic [LANES*DATA_W-1:0] in_w_data, out_w_data;
`ifdef WB_PIPE_PERF_EN
    logic [31:0]             perf_stall_cnt, perf_wr_cnt;
`endif

    always #5 clk = ~clk;

    wb_pipe_stage #(
        .LANES         (LANES),
        .ADDR_W        (ADDR_W),
        .DATA_W        (DATA_W),
        .ZERO_REG_DROP (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rdy        (rdy),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_w_addr  (in_w_addr),
        .in_w_req   (in_w_req),
        .in_w_data  (in_w_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_w_addr (out_w_addr),
        .out_w_req  (out_w_req),
        .out_w_data (out_w_data)
`ifdef WB_PIPE_PERF_EN
        ,
        .perf_stall_cnt (perf_stall_cnt),
        .perf_wr_cnt    (perf_wr_cnt)
`endif
    );

    int          checks = 0;
    int          errors = 0;
    int          dut_ret_cnt = 0;
    beat_t       sb[$];
    bit          mon_en = 1'b0;
    bit          m_accept = 1'b0;
    logic [31:0] m_stall = '0;
    logic [31:0] m_wr = '0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [LANES-1:0] filt(input beat_t b);
        logic [LANES-1:0] r;
        for (int i = 0; i < LANES; i++) begin
            r[i] = (b.addr[i*ADDR_W +: ADDR_W] == '0) ? 1'b0 : b.req[i];
        end
        return r;
    endfunction

    function automatic logic [31:0] pop(input logic [LANES-1:0] v);
        logic [31:0] c;
        c = 0;
        for (int i = 0; i < LANES; i++) c = c + 32'(v[i]);
        return c;
    endfunction

    task automatic rand_beat();
        for (int i = 0; i < LANES; i++) begin
            in_w_addr[i*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(0, 31));
            in_w_req[i]                   = 1'($urandom_range(0, 1));
            in_w_data[i*DATA_W +: DATA_W] = $urandom;
        end
    endtask

    // A beat is held until the model says it was taken, then replaced.
    task automatic tick(input bit iv, input bit ordy, input bit fl, input bit rd);
        @(posedge clk);
        #1;
        if (!in_valid || m_accept) rand_beat();
        in_valid  = iv;
        out_ready = ordy;
        flush     = fl;
        rdy       = rd;
    endtask

    // Reference model: queue holds the beats currently buffered in the stage.
    always @(negedge clk) begin : monitor
        beat_t obs;
        beat_t nb;
        bit    exp_ov;
        bit    exp_ir;
        bit    ret;
        if (mon_en) begin
            exp_ov = (sb.size() > 0);
            exp_ir = rdy && !flush && (sb.size() < 2);
            check("out_valid", out_valid, exp_ov);
            check("in_ready", in_ready, exp_ir);
            obs = {out_w_addr, out_w_req, out_w_data};
            if (exp_ov) check("out_beat", obs, sb[0]);
            else        check("out_w_req_idle", out_w_req, '0);
`ifdef WB_PIPE_PERF_EN
            check("perf_stall_cnt", perf_stall_cnt, m_stall);
            check("perf_wr_cnt", perf_wr_cnt, m_wr);
            if (rdy && exp_ov && !out_ready) m_stall = m_stall + 1;
`endif
            if (out_valid && out_ready && rdy) dut_ret_cnt++;
            ret      = exp_ov && out_ready && rdy;
            m_accept = in_valid && exp_ir;
            if (ret) begin
`ifdef WB_PIPE_PERF_EN
                m_wr = m_wr + pop(sb[0].req);
`endif
                void'(sb.pop_front());
            end
            if (rdy && flush) sb.delete();
            if (m_accept) begin
                nb     = {in_w_addr, in_w_req, in_w_data};
                nb.req = filt(nb);
                sb.push_back(nb);
            end
        end
    end

    initial begin : stim
        int          ret0;
        logic [31:0] wr0;
        rst = 1'b1; rdy = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_w_addr = '0; in_w_req = '0; in_w_data = '0;

        // Reset with rdy low
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_w_req", out_w_req, '0);
        check("rst_in_ready", in_ready, 1'b0);
`ifdef WB_PIPE_PERF_EN
        check("rst_perf_wr", perf_wr_cnt, 32'd0);
        check("rst_perf_stall", perf_stall_cnt, 32'd0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0; rdy = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1'b1);
        mon_en = 1'b1;

        // Streaming: 8 back-to-back beats
        ret0 = dut_ret_cnt;
        repeat (8) tick(1, 1, 0, 1);
        repeat (2) tick(0, 1, 0, 1);
        @(negedge clk);
        check("stream_retired", 32'(dut_ret_cnt - ret0), 32'd8);

        // Backpressure: skid fills, input blocked, drains in order
        repeat (2) tick(1, 1, 0, 1);
        repeat (3) tick(1, 0, 0, 1);
        @(negedge clk);
        check("bp_in_ready_low", in_ready, 1'b0);
        check("bp_out_valid", out_valid, 1'b1);
        repeat (3) tick(1, 1, 0, 1);
        repeat (3) tick(0, 1, 0, 1);

        // Flush with main+skid full and a beat on the input
        repeat (2) tick(1, 0, 0, 1);
        tick(1, 0, 1, 1);
        tick(0, 1, 0, 1);
        @(negedge clk);
        check("flush_out_valid", out_valid, 1'b0);
        check("flush_in_ready", in_ready, 1'b1);

        // Flush coinciding with a retire
        repeat (2) tick(1, 1, 0, 1);
        tick(1, 1, 1, 1);
        repeat (2) tick(0, 1, 0, 1);

        // rdy freeze with skid full, flush ignored while frozen
        repeat (2) tick(1, 1, 0, 1);
        tick(1, 0, 0, 1);
        repeat (4) tick(1, 1, 0, 0);
        tick(1, 1, 1, 0);
        @(negedge clk);
        check("freeze_out_valid", out_valid, 1'b1);
        check("freeze_in_ready", in_ready, 1'b0);
        repeat (3) tick(1, 1, 0, 1);
        repeat (3) tick(0, 1, 0, 1);

        // x0 filter: lane0 addr 0 dropped, lane1 addr 5 kept
        @(posedge clk);
        #1;
        wr0       = m_wr;
        in_w_addr = {5'd5, 5'd0};
        in_w_req  = 2'b11;
        in_w_data = {32'h1234_5678, 32'hDEAD_BEEF};
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("x0_out_w_req", out_w_req, 2'b10);
        check("x0_lane0_data", out_w_data[31:0], 32'hDEAD_BEEF);
        @(posedge clk);
        #1;
        @(negedge clk);
`ifdef WB_PIPE_PERF_EN
        check("x0_perf_wr", perf_wr_cnt, wr0 + 32'd1);
`else
        check("x0_model_wr", m_wr, wr0);
`endif

        repeat (3) tick(0, 1, 0, 1);
        @(negedge clk);
        check("drain_out_valid", out_valid, 1'b0);
        check("drain_sb_empty", 32'(sb.size()), 32'd0);
        mon_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
